imem_serial_loader: RTL
=======================

# imem_serial_loader

Byte-stream loader that writes instruction words into the writable instruction memory of the i281 CPU. It is the write side of the path the hardcoded BIOS banks read from. It sits between a byte source (UART receiver or debug port) and the instruction-memory write port. It frames a load with a sync byte, assembles big-endian 16-bit words, writes them to consecutive addresses, validates an 8-bit checksum, and holds the CPU until a clean load completes.

## Interface
- WORDS, 32: number of instruction words per load; a power of two, at least 2.
- ADDR_W, 5: log2(WORDS), the width of the memory address.
- SYNC_BYTE, 8'hA5: byte that starts a load frame.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data is valid this cycle.
- rx_ready  out  1  loader accepts a byte this cycle; a byte transfers when rx_valid && rx_ready at a rising edge.
- imem_we  out  1  one-cycle write strobe to instruction memory.
- imem_addr  out  ADDR_W  write address.
- imem_wdata  out  16  write data.
- cpu_hold  out  1  holds the CPU (PC and fetch) while 1.
- load_done  out  1  last load passed its checksum.
- load_err  out  1  last load failed its checksum.

## Operation
- States: IDLE, RECV_HI, RECV_LO, RECV_CK, CHECK, DONE, ERROR.
- Reset values:
  - state = IDLE, word counter = 0, checksum accumulator = 0.
  - imem_we = 0, imem_addr = 0, imem_wdata = 0.
  - cpu_hold = 1, load_done = 0, load_err = 0.
- IDLE:
  - An accepted byte equal to SYNC_BYTE goes to RECV_HI and clears the counter and accumulator.
  - Any other byte is discarded.
- RECV_HI: the accepted byte is latched as the high byte; go to RECV_LO.
- RECV_LO: the accepted byte completes the word.
  - The registered write is issued: imem_wdata = {hi, lo}, imem_addr = counter, imem_we = 1.
  - The counter then increments.
  - If counter was WORDS-1, go to RECV_CK; otherwise go to RECV_HI.
- Checksum: the accumulator adds every data byte, high and low, modulo 256. The sync and checksum bytes are excluded.
- RECV_CK: the accepted byte is compared with the accumulator; go to CHECK.
- CHECK (one cycle, rx_ready = 0):
  - Match: go to DONE with load_done = 1, load_err = 0, cpu_hold = 0.
  - Mismatch: go to ERROR with load_err = 1, load_done = 0, cpu_hold = 1.
- DONE / ERROR:
  - An accepted SYNC_BYTE starts a new load: go to RECV_HI, clear the counter and accumulator, set cpu_hold = 1, clear load_done and load_err.
  - Other bytes are discarded.
- Words that were written stay written even when the checksum fails. A failed load only keeps the CPU held.
- Inside a frame (RECV_HI, RECV_LO, RECV_CK), SYNC_BYTE is ordinary data. There is no resync mid-frame.
- The address counter is ADDR_W bits wide. It wraps to 0 after WORDS-1. The wrap is never used for a write within one frame.
- cpu_hold rises in the same edge that accepts a restarting sync byte. No write can occur before the CPU is held.

## Timing
- rx_ready = 1 in every state except CHECK.
- No backpressure originates from memory; the memory write always completes in one cycle.
- Write latency: low byte accepted at edge N, so imem_we = 1 for exactly the cycle between edges N and N+1. imem_addr and imem_wdata are valid in that same cycle.
- imem_addr and imem_wdata hold their last values when imem_we = 0.
- Back-to-back bytes (rx_valid held high) are accepted one per cycle. A full frame takes 2·WORDS + 2 accepted bytes plus one CHECK cycle.
- Status latency: checksum byte accepted at edge N; CHECK occupies N to N+1; load_done or load_err and cpu_hold change at edge N+1.
- Gaps (rx_valid = 0) are allowed anywhere in the frame. State is held indefinitely; there is no timeout.
- An asynchronous Reset_n assertion mid-frame immediately forces all outputs to their reset values.
  - imem_we drops without waiting for a clock edge.
  - The partial load is abandoned. Already-written words are not rolled back.

## Test plan
- Reset, then send A5, 64 bytes 0x00..0x3F, and checksum 0xE0 (= sum mod 256) back-to-back.
  - Expect 32 writes with addr k and data {2k, 2k+1}.
  - Expect load_done = 1 and cpu_hold = 0 at the edge after CHECK.
- Same frame with checksum 0xE1: all 32 writes occur, then load_err = 1, load_done = 0, cpu_hold stays 1.
- Send junk bytes 0x00, 0xFF, 0x5A before A5: no writes. The frame then loads normally.
- Data containing A5 mid-frame: it is written as data (e.g. word 0 = 16'hA5A5). The frame still completes with a correct checksum.
- Random rx_valid gaps (30% idle) during a valid frame: same writes and status as the back-to-back case. rx_ready is low only in the CHECK cycle.
- Assert Reset_n low after 10 words:
  - Outputs return immediately to their reset values: imem_we = 0, cpu_hold = 1.
  - The next complete frame loads from addr 0 and reaches DONE.
- From DONE, a new A5: cpu_hold returns to 1 and load_done clears at the accepting edge.

Source files
------------

// File: rtl/imem_serial_loader_if.sv
// Byte-stream and instruction-memory write bundle for the serial loader.
// The loader drives the memory write port, rx_ready and status outputs.
interface imem_serial_loader_if #(
    parameter int ADDR_W = 5
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_wdata;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;

    modport master (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata,
        output cpu_hold,
        output load_done,
        output load_err
    );

    modport slave (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata,
        input  cpu_hold,
        input  load_done,
        input  load_err
    );
endinterface

// File: rtl/imem_serial_loader.sv
// Sync-framed byte loader into i281 instruction memory.
// Big-endian words, 8-bit additive checksum, CPU held until a clean load.
module imem_serial_loader #(
    parameter int          WORDS     = 32,
    parameter int          ADDR_W    = 5,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    imem_serial_loader_if.master bus
);
    typedef enum logic [2:0] {
        IDLE,
        RECV_HI,
        RECV_LO,
        RECV_CK,
        CHECK,
        DONE,
        ERROR
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WORDS - 1);
    localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

    state_t            state, state_n;
    logic [ADDR_W-1:0] cnt, cnt_n;
    logic [7:0]        acc, acc_n;
    logic [7:0]        hi, hi_n;
    logic              ok, ok_n;
    logic              we_q, we_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [15:0]       wdata_q, wdata_n;
    logic              hold_q, hold_n;
    logic              done_q, done_n;
    logic              err_q, err_n;
    logic              take;
    logic              is_sync;

    assign bus.rx_ready   = (state != CHECK);
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.cpu_hold   = hold_q;
    assign bus.load_done  = done_q;
    assign bus.load_err   = err_q;

    assign take    = bus.rx_valid && (state != CHECK);
    assign is_sync = (bus.rx_data == SYNC_BYTE);

    // Next-state, word assembly, checksum and status decisions.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        acc_n   = acc;
        hi_n    = hi;
        ok_n    = ok;
        we_n    = 1'b0;
        addr_n  = addr_q;
        wdata_n = wdata_q;
        hold_n  = hold_q;
        done_n  = done_q;
        err_n   = err_q;
        unique case (state)
            IDLE, DONE, ERROR: begin
                if (take && is_sync) begin
                    state_n = RECV_HI;
                    cnt_n   = '0;
                    acc_n   = '0;
                    hold_n  = 1'b1;
                    done_n  = 1'b0;
                    err_n   = 1'b0;
                end
            end
            RECV_HI: begin
                if (take) begin
                    hi_n    = bus.rx_data;
                    acc_n   = acc + bus.rx_data;
                    state_n = RECV_LO;
                end
            end
            RECV_LO: begin
                if (take) begin
                    we_n    = 1'b1;
                    addr_n  = cnt;
                    wdata_n = {hi, bus.rx_data};
                    acc_n   = acc + bus.rx_data;
                    cnt_n   = cnt + ONE;
                    state_n = (cnt == LAST) ? RECV_CK : RECV_HI;
                end
            end
            RECV_CK: begin
                if (take) begin
                    ok_n    = (bus.rx_data == acc);
                    state_n = CHECK;
                end
            end
            CHECK: begin
                if (ok) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                    err_n   = 1'b0;
                    hold_n  = 1'b0;
                end else begin
                    state_n = ERROR;
                    done_n  = 1'b0;
                    err_n   = 1'b1;
                    hold_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and registered outputs; reset forces outputs immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            hi      <= '0;
            ok      <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            acc     <= acc_n;
            hi      <= hi_n;
            ok      <= ok_n;
            we_q    <= we_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
            hold_q  <= hold_n;
            done_q  <= done_n;
            err_q   <= err_n;
        end
    end
endmodule
